// File: rtl/nv_csa_reduce_seq.sv
// Multi-beat carry-save reduction sequencer: folds NUM_IN lanes per beat into a sum/carry pair,
// then resolves with one carry-propagate add. Define NVDLA_CSA_SEQ_SAT_EN for saturating output.
module nv_csa_reduce_seq #(
   parameter int unsigned NUM_IN = 8,
   parameter int unsigned IN_W   = 8,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned OUT_W  = 24
) (
   input  logic                     nvdla_core_clk,
   input  logic                     nvdla_core_rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic [NUM_IN-1:0]        in_mask,
   input  logic [NUM_IN*IN_W-1:0]   in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_data,
   output logic [15:0]              out_beats,
   output logic                     out_sat,
   output logic                     busy
);

   localparam int NumOps = int'(NUM_IN) + 2;
`ifdef NVDLA_CSA_SEQ_SAT_EN
   localparam int unsigned ResW = ACC_W;
`else
   localparam int unsigned ResW = OUT_W;
`endif

   typedef enum logic [1:0] {StIdle, StAcc, StAdd, StOut} state_e;

   state_e             r_state, w_state_nxt;
   logic [ACC_W-1:0]   r_sum, r_carry;
   logic [15:0]        r_beat_cnt, r_beats;
   logic [ResW-1:0]    r_res;

   logic               w_accept;
   logic [15:0]        w_beat_inc;
   logic [ACC_W-1:0]   w_ops [NumOps];
   logic [ACC_W-1:0]   w_tree_sum, w_tree_carry;

   assign in_ready  = (r_state == StIdle) || (r_state == StAcc);
   assign out_valid = (r_state == StOut);
   assign busy      = (r_state != StIdle);
   assign out_beats = r_beats;
   assign w_accept  = in_valid & in_ready;
   assign w_beat_inc = (r_beat_cnt == 16'hFFFF) ? r_beat_cnt : r_beat_cnt + 16'd1;

   for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
      logic [IN_W-1:0] w_lane;
      assign w_lane   = in_data[g*IN_W +: IN_W];
      assign w_ops[g] = in_mask[g] ? {{(ACC_W-IN_W){w_lane[IN_W-1]}}, w_lane} : '0;
   end
   assign w_ops[NumOps-2] = r_sum;
   assign w_ops[NumOps-1] = r_carry;

   // Level-by-level 3:2 compression; operands left over from a level pass straight through.
   always_comb begin : b_tree
      logic [ACC_W-1:0] w_lvl [NumOps];
      logic [ACC_W-1:0] w_nxt [NumOps];
      int               n, m, rem;
      w_lvl = w_ops;
      n     = NumOps;
      for (int l = 0; l < NumOps; l++) begin
         for (int k = 0; k < NumOps; k++) w_nxt[k] = '0;
         m   = 0;
         rem = n - 3 * (n / 3);
         if (n > 2) begin
            for (int g = 0; g < NumOps / 3; g++) begin
               if (3 * g + 2 < n) begin
                  w_nxt[m]     = w_lvl[3*g] ^ w_lvl[3*g+1] ^ w_lvl[3*g+2];
                  w_nxt[m+1]   = ((w_lvl[3*g] & w_lvl[3*g+1]) | (w_lvl[3*g] & w_lvl[3*g+2]) |
                                  (w_lvl[3*g+1] & w_lvl[3*g+2])) << 1;
                  m            = m + 2;
               end
            end
            for (int r = 0; r < 2; r++) begin
               if (r < rem) begin
                  w_nxt[m] = w_lvl[3*(n/3)+r];
                  m        = m + 1;
               end
            end
            w_lvl = w_nxt;
            n     = m;
         end
      end
      w_tree_sum   = w_lvl[0];
      w_tree_carry = w_lvl[1];
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_nxt = in_last ? StAdd : StAcc;
         StAcc:   if (w_accept && in_last) w_state_nxt = StAdd;
         StAdd:   w_state_nxt = StOut;
         StOut:   if (out_ready) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         r_sum      <= '0;
         r_carry    <= '0;
         r_beat_cnt <= '0;
         r_beats    <= '0;
         r_res      <= '0;
      end else begin
         if (w_accept) begin
            r_sum      <= w_tree_sum;
            r_carry    <= w_tree_carry;
            r_beat_cnt <= w_beat_inc;
         end
         if (r_state == StAdd) begin
            r_res   <= ResW'(r_sum + r_carry);
            r_beats <= r_beat_cnt;
         end
         if ((r_state == StOut) && out_ready) begin
            r_sum      <= '0;
            r_carry    <= '0;
            r_beat_cnt <= '0;
         end
      end
   end

`ifdef NVDLA_CSA_SEQ_SAT_EN
   localparam logic [ACC_W-1:0] MaxV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MinV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   always_comb begin
      out_data = r_res[OUT_W-1:0];
      out_sat  = 1'b0;
      if ($signed(r_res) > $signed(MaxV)) begin
         out_data = MaxV[OUT_W-1:0];
         out_sat  = 1'b1;
      end else if ($signed(r_res) < $signed(MinV)) begin
         out_data = MinV[OUT_W-1:0];
         out_sat  = 1'b1;
      end
   end
`else
   assign out_data = r_res;
   assign out_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_nv_csa_reduce_seq.sv
// Randomized self-checking bench: two instances (OUT_W 24 and 8) share stimulus and are checked
// against a plain-arithmetic sum model; honours NVDLA_CSA_SEQ_SAT_EN when defined.
module tb_nv_csa_reduce_seq;

   localparam int NI  = 8;
   localparam int IW  = 8;
   localparam int AW  = 32;
   localparam int OWA = 24;
   localparam int OWB = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_last, out_ready;
   logic [NI-1:0]     in_mask;
   logic [NI*IW-1:0]  in_data;

   logic              in_ready_a, out_valid_a, out_sat_a, busy_a;
   logic [OWA-1:0]    out_data_a;
   logic [15:0]       out_beats_a;
   logic              in_ready_b, out_valid_b, out_sat_b, busy_b;
   logic [OWB-1:0]    out_data_b;
   logic [15:0]       out_beats_b;

   int n_cmp = 0;
   int n_err = 0;

   logic [NI*IW-1:0]  v_data [$];
   logic [NI-1:0]     v_mask [$];

   always #5 clk = ~clk;

   nv_csa_reduce_seq #(.NUM_IN(NI), .IN_W(IW), .ACC_W(AW), .OUT_W(OWA)) u_dut_a (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready_a),
      .in_last        (in_last),
      .in_mask        (in_mask),
      .in_data        (in_data),
      .out_valid      (out_valid_a),
      .out_ready      (out_ready),
      .out_data       (out_data_a),
      .out_beats      (out_beats_a),
      .out_sat        (out_sat_a),
      .busy           (busy_a)
   );

   nv_csa_reduce_seq #(.NUM_IN(NI), .IN_W(IW), .ACC_W(AW), .OUT_W(OWB)) u_dut_b (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready_b),
      .in_last        (in_last),
      .in_mask        (in_mask),
      .in_data        (in_data),
      .out_valid      (out_valid_b),
      .out_ready      (out_ready),
      .out_data       (out_data_b),
      .out_beats      (out_beats_b),
      .out_sat        (out_sat_b),
      .busy           (busy_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Result expected for an OUT_W of w, given the exact integer sum of all unmasked operands.
   function automatic void exp_out(input longint s, input int w,
                                   output logic [63:0] d, output logic sat);
      logic [31:0] t;
      longint      sv, hi, lo, mk;
      t  = s[31:0];
      sv = longint'($signed(t));
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      mk = (longint'(1) << w) - 1;
`ifdef NVDLA_CSA_SEQ_SAT_EN
      if (sv > hi) begin
         d = 64'(hi & mk); sat = 1'b1;
      end else if (sv < lo) begin
         d = 64'(lo & mk); sat = 1'b1;
      end else begin
         d = 64'(sv & mk); sat = 1'b0;
      end
`else
      d   = 64'(longint'(t) & mk);
      sat = 1'b0;
`endif
   endfunction

   task automatic chk_result(input string tag, input longint s, input int nb);
      logic [63:0] d;
      logic        sat;
      exp_out(s, OWA, d, sat);
      chk({tag, "/a_valid"}, 64'(out_valid_a), 64'd1);
      chk({tag, "/a_data"},  64'(out_data_a), d);
      chk({tag, "/a_sat"},   64'(out_sat_a), 64'(sat));
      chk({tag, "/a_beats"}, 64'(out_beats_a), 64'(nb));
      exp_out(s, OWB, d, sat);
      chk({tag, "/b_valid"}, 64'(out_valid_b), 64'd1);
      chk({tag, "/b_data"},  64'(out_data_b), d);
      chk({tag, "/b_sat"},   64'(out_sat_b), 64'(sat));
      chk({tag, "/b_beats"}, 64'(out_beats_b), 64'(nb));
   endtask

   // Streams the queued beats as one vector, then checks ADD/OUT timing and the result.
   task automatic do_vec(input string tag, input int delay, input bit gaps);
      longint       s;
      int           nb;
      logic [IW-1:0] lane;
      nb = v_data.size();
      s  = 0;
      for (int b = 0; b < nb; b++) begin
         for (int l = 0; l < NI; l++) begin
            lane = v_data[b][l*IW +: IW];
            if (v_mask[b][l]) s += longint'($signed(lane));
         end
      end
      for (int b = 0; b < nb; b++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk({tag, "/hold_busy"}, 64'(busy_a), (b > 0) ? 64'd1 : 64'd0);
         end
         in_valid = 1'b1;
         in_data  = v_data[b];
         in_mask  = v_mask[b];
         in_last  = (b == nb - 1);
         chk({tag, "/in_ready"}, 64'(in_ready_a), 64'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk({tag, "/add_valid"}, 64'(out_valid_a), 64'd0);
      chk({tag, "/add_ready"}, 64'(in_ready_a), 64'd0);
      chk({tag, "/add_busy"},  64'(busy_a), 64'd1);
      @(posedge clk); #1;
      for (int c = 0; c <= delay; c++) begin
         chk_result(tag, s, nb);
         chk({tag, "/out_ready"}, 64'(in_ready_a), 64'd0);
         if (c < delay) begin
            @(posedge clk); #1;
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "/idle_valid_a"}, 64'(out_valid_a), 64'd0);
      chk({tag, "/idle_valid_b"}, 64'(out_valid_b), 64'd0);
      chk({tag, "/idle_busy"},    64'(busy_a), 64'd0);
      chk({tag, "/idle_ready"},   64'(in_ready_a), 64'd1);
      v_data.delete();
      v_mask.delete();
   endtask

   function automatic logic [NI*IW-1:0] fill(input logic [IW-1:0] v);
      logic [NI*IW-1:0] d;
      for (int l = 0; l < NI; l++) d[l*IW +: IW] = v;
      return d;
   endfunction

   initial begin
      logic [NI*IW-1:0] d;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_mask   = '0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst/in_ready",  64'(in_ready_a), 64'd1);
      chk("rst/out_valid", 64'(out_valid_a), 64'd0);
      chk("rst/out_data",  64'(out_data_a), 64'd0);
      chk("rst/out_beats", 64'(out_beats_a), 64'd0);
      chk("rst/out_sat",   64'(out_sat_a), 64'd0);
      chk("rst/busy",      64'(busy_a), 64'd0);
      rst = 1'b0;

      for (int l = 0; l < NI; l++) d[l*IW +: IW] = IW'(l + 1);
      v_data.push_back(d);
      v_mask.push_back('1);
      do_vec("one_beat", 0, 1'b0);

      repeat (3) begin
         v_data.push_back(fill(8'hFF));
         v_mask.push_back('1);
      end
      do_vec("neg3", 0, 1'b0);

      v_data.push_back(fill(8'd127));
      v_mask.push_back('1);
      v_data.push_back(fill(8'd127));
      v_mask.push_back(8'h0F);
      do_vec("mask2", 0, 1'b0);

      v_data.push_back(fill(8'd3));
      v_mask.push_back('1);
      v_data.push_back(fill(8'hFE));
      v_mask.push_back(8'h00);
      do_vec("stall5", 5, 1'b0);

      v_data.push_back(fill(8'd100));
      v_mask.push_back('1);
      do_vec("ovf", 0, 1'b0);

      // Two beats of an abandoned vector, then reset from ACC.
      in_valid = 1'b1;
      in_data  = fill(8'd5);
      in_mask  = '1;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst/busy",      64'(busy_a), 64'd0);
      chk("mid_rst/out_valid", 64'(out_valid_a), 64'd0);
      chk("mid_rst/in_ready",  64'(in_ready_a), 64'd1);
      v_data.push_back(fill(8'd1));
      v_mask.push_back('1);
      do_vec("after_rst", 0, 1'b0);

      for (int v = 0; v < 40; v++) begin
         int nb;
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin
            v_data.push_back({$urandom, $urandom});
            v_mask.push_back(($urandom_range(0, 7) == 0) ? NI'(0) : NI'($urandom));
         end
         do_vec("rand", $urandom_range(0, 3), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
